// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
//   APB requester. Accepts single read/write commands from a host over a
//   valid/ready handshake and runs each one as an APB SETUP/ACCESS transfer.
//   The slave id is decoded into a one-hot select. Wait states are inserted
//   while the slave holds ready low. After TIMEOUT_CYC ACCESS cycles without
//   ready the transfer aborts with an error. Every accepted command produces
//   exactly one single-cycle response pulse.
//
// Ports
//   i_clk, i_reset_n        clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready host command handshake
//   i_cmd_write/id/addr/wdata  command fields
//   o_rsp_valid/rdata/err   single-cycle response (rdata is 0 for writes/errors)
//   o_busy                  bridge is not idle
//   o_sel/o_enable/o_write/o_addr/o_wdata  APB requester outputs
//   i_rdata/i_ready         APB completer inputs, only looked at in ACCESS
// ---------------------------------------------------------------------------
module apb_master_bridge #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int NUM_SLAVES  = 4,
  parameter int TIMEOUT_CYC = 16,
  localparam int ID_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_write,
  input  logic [ID_W-1:0]       i_cmd_id,
  input  logic [ADDR_W-1:0]     i_cmd_addr,
  input  logic [DATA_W-1:0]     i_cmd_wdata,
  output logic                  o_rsp_valid,
  output logic [DATA_W-1:0]     o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_busy,
  output logic [NUM_SLAVES-1:0] o_sel,
  output logic                  o_enable,
  output logic                  o_write,
  output logic [ADDR_W-1:0]     o_addr,
  output logic [DATA_W-1:0]     o_wdata,
  input  logic [DATA_W-1:0]     i_rdata,
  input  logic                  i_ready
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  // Counter value seen during the last allowed ACCESS cycle.
  localparam logic [CNT_W-1:0] CNT_LIMIT =
    (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_write;
  logic [ID_W-1:0]     r_id;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_rsp_valid;
  logic                r_rsp_err;
  logic [DATA_W-1:0]   r_rsp_rdata;

  logic                w_cmd_ready;
  logic                w_accept;
  logic                w_cmd_id_bad;
  logic                w_reg_id_bad;
  logic                w_cnt_limit;
  logic                w_rsp_valid_next;
  logic                w_rsp_err_next;
  logic [DATA_W-1:0]   w_rsp_rdata_next;

  assign w_cmd_id_bad = (32'(i_cmd_id) >= 32'(NUM_SLAVES));
  assign w_reg_id_bad = (32'(r_id) >= 32'(NUM_SLAVES));
  assign w_cnt_limit  = (TIMEOUT_CYC > 0) && (r_cnt == CNT_LIMIT);
  assign w_accept     = i_cmd_valid && w_cmd_ready;

  always_comb begin
    w_state_next     = r_state;
    w_cmd_ready      = 1'b0;
    w_rsp_valid_next = 1'b0;
    w_rsp_err_next   = 1'b0;
    w_rsp_rdata_next = '0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          if (w_cmd_id_bad) begin
            // Bad id from idle: answer with an error, never touch the bus.
            w_rsp_valid_next = 1'b1;
            w_rsp_err_next   = 1'b1;
          end else begin
            w_state_next = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        // A bad id can only get here when it was accepted back-to-back at an
        // ACCESS completion; its select decodes to zero, so no slave sees it,
        // and its error response follows the previous transfer's response.
        if (w_reg_id_bad) begin
          w_state_next     = S_IDLE;
          w_rsp_valid_next = 1'b1;
          w_rsp_err_next   = 1'b1;
        end else begin
          w_state_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (i_ready) begin
          w_cmd_ready      = 1'b1;
          w_rsp_valid_next = 1'b1;
          w_rsp_rdata_next = r_write ? '0 : i_rdata;
          w_state_next     = i_cmd_valid ? S_SETUP : S_IDLE;
        end else if (w_cnt_limit) begin
          w_state_next     = S_IDLE;
          w_rsp_valid_next = 1'b1;
          w_rsp_err_next   = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_write     <= 1'b0;
      r_id        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_write <= i_cmd_write;
        r_id    <= i_cmd_id;
        r_addr  <= i_cmd_addr;
        r_wdata <= i_cmd_wdata;
      end
      // Counts ACCESS cycles spent waiting; saturates instead of wrapping.
      if (w_state_next == S_SETUP) begin
        r_cnt <= '0;
      end else if ((r_state == S_ACCESS) && !i_ready && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_err   <= w_rsp_err_next;
      r_rsp_rdata <= w_rsp_rdata_next;
    end
  end

  // Select is decoded from state so an asynchronous reset drops it at once.
  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
    assign o_sel[gi] = (r_state != S_IDLE) && (r_id == ID_W'(gi));
  end

  assign o_cmd_ready = w_cmd_ready;
  assign o_busy      = (r_state != S_IDLE);
  assign o_enable    = (r_state == S_ACCESS);
  assign o_write     = r_write;
  assign o_addr      = r_addr;
  assign o_wdata     = r_wdata;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_err   = r_rsp_err;
  assign o_rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_apb_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_master_bridge
//   Scoreboard bench for apb_master_bridge (3 slaves, timeout 16). A driver
//   issues commands and pushes the expected response, bus transfer and slave
//   wait count into queues; a behavioural APB slave with its own memory
//   serves the bus; a monitor pops and compares every response.
// ---------------------------------------------------------------------------
module tb_apb_master_bridge;
  localparam int NSL  = 3;
  localparam int TO   = 16;
  localparam int ID_W = 2;

  logic clk = 1'b0;
  logic reset_n;
  logic cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [ID_W-1:0] cmd_id = '0;
  logic [7:0] cmd_addr = '0, cmd_wdata = '0;
  logic cmd_ready, rsp_valid, rsp_err, busy, enable, write;
  logic [7:0] rsp_rdata, addr, wdata;
  logic [7:0] rdata = '0;
  logic ready = 1'b0;
  logic [NSL-1:0] sel;

  int checks = 0, failures = 0, cyc = 0, rsp_count = 0, last_access_len = 0;

  typedef struct { logic err; logic [7:0] data; int acc; int lat; } exp_t;
  typedef struct { logic [NSL-1:0] sel; logic wr; logic [7:0] a; logic [7:0] d; } bus_t;
  exp_t exp_q[$];
  bus_t bus_q[$];
  int   wait_q[$];
  logic [7:0] mdl_mem [NSL*256];
  logic [7:0] slv_mem [NSL*256];

  apb_master_bridge #(.ADDR_W(8), .DATA_W(8), .NUM_SLAVES(NSL), .TIMEOUT_CYC(TO)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_write(cmd_write), .i_cmd_id(cmd_id), .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err), .o_busy(busy),
    .o_sel(sel), .o_enable(enable), .o_write(write), .o_addr(addr), .o_wdata(wdata),
    .i_rdata(rdata), .i_ready(ready)
  );

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  initial begin #500000; $display("FAIL watchdog expired"); $fatal(1); end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Behavioural APB slave: wait count per transfer comes from wait_q.
  initial begin
    int acc_k = 0, cur_wait = 0, id = 0;
    bus_t cap, e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        acc_k = 0; ready = 1'b0;
      end else if (sel != '0 && !enable) begin
        chk("setup_onehot", int'($onehot(sel)), 1);
        if (wait_q.size() == 0 || bus_q.size() == 0) begin
          chk("unexpected_setup", 1, 0);
          cur_wait = 0;
        end else begin
          cur_wait = wait_q.pop_front();
          e = bus_q.pop_front();
          chk("setup_sel", int'(sel), int'(e.sel));
          chk("setup_write", int'(write), int'(e.wr));
          chk("setup_addr", int'(addr), int'(e.a));
          chk("setup_wdata", int'(wdata), int'(e.d));
        end
        cap.sel = sel; cap.wr = write; cap.a = addr; cap.d = wdata;
        acc_k = 0;
        ready = 1'($urandom); rdata = 8'($urandom);
      end else if (enable) begin
        acc_k++;
        chk("access_hold", int'({sel, write, addr, wdata} == {cap.sel, cap.wr, cap.a, cap.d}), 1);
        id = 0;
        for (int i = 0; i < NSL; i++) if (sel[i]) id = i;
        if (acc_k > cur_wait) begin
          ready = 1'b1;
          last_access_len = acc_k;
          if (write) begin
            slv_mem[id*256 + int'(addr)] = wdata;
            rdata = 8'($urandom);
          end else begin
            rdata = slv_mem[id*256 + int'(addr)];
          end
        end else begin
          ready = 1'b0; rdata = 8'($urandom);
        end
      end else begin
        ready = 1'($urandom); rdata = 8'($urandom);
      end
    end
  end

  // Response monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (reset_n && rsp_valid) begin
        rsp_count++;
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_err", int'(rsp_err), int'(e.err));
          chk("rsp_rdata", int'(rsp_rdata), int'(e.data));
          if (e.lat >= 0) chk("rsp_latency", cyc - e.acc + 1, e.lat);
          $display("rsp #%0d err=%0d rdata=%0d lat=%0d", rsp_count, rsp_err, rsp_rdata, cyc - e.acc + 1);
        end
      end
    end
  end

  task automatic issue(input int wr, input int id, input int a, input int d, input int waits,
                       output int acc_busy);
    exp_t e; bus_t b; bit done = 0;
    acc_busy = 0;
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge clk); #2;
      cmd_valid = 1'b1; cmd_write = 1'(wr); cmd_id = ID_W'(id);
      cmd_addr = 8'(a); cmd_wdata = 8'(d);
      #1;
      if (cmd_ready) begin
        done = 1; acc_busy = int'(busy);
        e.acc = cyc + 1;
        if (id >= NSL) begin
          e.err = 1'b1; e.data = '0; e.lat = busy ? -1 : 1;
        end else begin
          wait_q.push_back(waits);
          b.sel = NSL'(1 << id); b.wr = 1'(wr); b.a = 8'(a); b.d = 8'(d);
          bus_q.push_back(b);
          if (waits >= TO) begin
            e.err = 1'b1; e.data = '0; e.lat = TO + 2;
          end else begin
            e.err = 1'b0; e.lat = 3 + waits;
            if (wr != 0) begin e.data = '0; mdl_mem[id*256 + a] = 8'(d); end
            else e.data = mdl_mem[id*256 + a];
          end
        end
        exp_q.push_back(e);
        $display("cmd wr=%0d id=%0d addr=%0d wdata=%0d waits=%0d busy=%0d", wr, id, a, d, waits, acc_busy);
      end
    end
    if (!done) chk("cmd_accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(negedge clk); #2; cmd_valid = 1'b0; end
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin @(negedge clk); #2; t++; end
    chk({nm, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int bz, r, w, rc;
    logic [7:0] v;
    for (int i = 0; i < NSL*256; i++) begin v = 8'($urandom); mdl_mem[i] = v; slv_mem[i] = v; end
    reset_n = 1'b1; #1 reset_n = 1'b0;
    #12;
    chk("reset_bus", int'({sel, enable, write, addr, wdata}), 0);
    chk("reset_rsp", int'({rsp_valid, rsp_err, rsp_rdata}), 0);
    chk("reset_busy", int'(busy), 0);
    @(negedge clk); @(negedge clk); reset_n = 1'b1;

    issue(1, 1, 6, 5, 0, bz); idle(1); drain("t1_write");
    issue(0, 1, 6, 0, 0, bz); idle(1); drain("t2_read");
    issue(1, 2, 5, 4, 5, bz); idle(1); drain("t3_wait");
    chk("t3_enable_cycles", last_access_len, 6);
    issue(0, 1, 9, 0, TO, bz); idle(1); drain("t4_timeout");
    chk("t4_sel_after_abort", int'(sel), 0);
    issue(1, 0, 3, 8'hA5, 0, bz);
    issue(1, 0, 4, 8'h5A, 0, bz);
    chk("t5_b2b_accept_in_access", bz, 1);
    idle(1); drain("t5_b2b");
    issue(0, 3, 1, 0, 0, bz); idle(1);
    chk("t6_badid_no_sel", int'({sel, busy}), 0);
    drain("t6_badid");

    // Reset in the middle of a long ACCESS phase.
    issue(0, 2, 7, 0, 10, bz); idle(1);
    for (int t = 0; t < 20 && !enable; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_sel_enable", int'({sel, enable}), 0);
    exp_q.delete(); bus_q.delete(); wait_q.delete();
    rc = rsp_count;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle(6);
    chk("rst_no_rsp", rsp_count - rc, 0);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 19));
      if (r < 12) w = int'($urandom_range(0, 3));
      else if (r < 15) w = 15;
      else if (r < 17) w = int'($urandom_range(16, 18));
      else w = 6;
      issue(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 255)), w, bz);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(1);
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
